// File: rtl/deck_dealer.sv
// rtl/deck_dealer.sv - captures a shuffled 52-card stream into deck memory and deals it out decoded
module deck_dealer #(
    parameter int DECK_SIZE = 52,
    parameter int CARD_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              newDeck,
    input  logic              loadFlag,
    input  logic [CARD_W-1:0] card,
    output logic              shuffleFlag,
    input  logic              dealReq,
    output logic              dealValid,
    output logic [CARD_W-1:0] dealCard,
    output logic [3:0]        rank,
    output logic [1:0]        suit,
    output logic [5:0]        cardsLeft,
    output logic              deckReady,
    output logic              deckEmpty,
    output logic              loadErr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2,
        EMPTY = 2'd3
    } state_t;

    localparam logic [5:0]        LAST_IDX  = 6'(DECK_SIZE - 1);
    localparam logic [5:0]        FULL_CNT  = 6'(DECK_SIZE);
    localparam logic [CARD_W-1:0] NUM_CODES = CARD_W'(DECK_SIZE);
    localparam int                CODE_SPACE = 2 ** CARD_W;

    state_t              state;
    logic [5:0]          wrPtr;
    logic [5:0]          rdPtr;
    logic [DECK_SIZE-1:0] seen;
    logic [CARD_W-1:0]   mem [0:DECK_SIZE-1];

    // Seen mask widened to the full code space so out-of-range codes index safely
    logic [CODE_SPACE-1:0] seen_ext;
    logic                  code_ok;
    logic                  wr_en;
    logic [CARD_W-1:0]     rd_word;
    logic [3:0]            dec_rank;
    logic [1:0]            dec_suit;

    assign seen_ext = {{(CODE_SPACE - DECK_SIZE){1'b0}}, seen};
    assign code_ok  = (card < NUM_CODES);
    assign wr_en    = (state == LOAD) && loadFlag && code_ok && !seen_ext[card];
    assign rd_word  = mem[rdPtr];

    // Split the card code into suit (code/13) and rank (code mod 13, plus one)
    always_comb begin
        dec_suit = 2'd0;
        dec_rank = 4'(rd_word + 6'd1);
        if (rd_word >= 6'd39) begin
            dec_suit = 2'd3;
            dec_rank = 4'(rd_word - 6'd38);
        end else if (rd_word >= 6'd26) begin
            dec_suit = 2'd2;
            dec_rank = 4'(rd_word - 6'd25);
        end else if (rd_word >= 6'd13) begin
            dec_suit = 2'd1;
            dec_rank = 4'(rd_word - 6'd12);
        end
    end

    // Deck storage: accepted codes land at the write pointer, contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wrPtr[5:0]] <= card;
        end
    end

    // Control FSM with registered status and deal outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            wrPtr       <= 6'd0;
            rdPtr       <= 6'd0;
            seen        <= '0;
            shuffleFlag <= 1'b0;
            dealValid   <= 1'b0;
            dealCard    <= '0;
            rank        <= 4'd0;
            suit        <= 2'd0;
            cardsLeft   <= 6'd0;
            deckReady   <= 1'b0;
            deckEmpty   <= 1'b0;
            loadErr     <= 1'b0;
        end else begin
            dealValid <= 1'b0;
            case (state)
                IDLE, EMPTY, READY: begin
                    if (newDeck) begin
                        // newDeck outranks a same-cycle dealReq
                        state       <= LOAD;
                        wrPtr       <= 6'd0;
                        rdPtr       <= 6'd0;
                        seen        <= '0;
                        loadErr     <= 1'b0;
                        shuffleFlag <= 1'b1;
                        cardsLeft   <= 6'd0;
                        deckReady   <= 1'b0;
                        deckEmpty   <= 1'b0;
                    end else if (state == READY && dealReq) begin
                        dealValid <= 1'b1;
                        dealCard  <= rd_word;
                        rank      <= dec_rank;
                        suit      <= dec_suit;
                        rdPtr     <= rdPtr + 6'd1;
                        cardsLeft <= cardsLeft - 6'd1;
                        if (rdPtr == LAST_IDX) begin
                            state     <= EMPTY;
                            deckReady <= 1'b0;
                            deckEmpty <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (loadFlag) begin
                        if (!code_ok || seen_ext[card]) begin
                            loadErr <= 1'b1;
                        end else begin
                            seen  <= seen | ({{(DECK_SIZE - 1){1'b0}}, 1'b1} << card);
                            wrPtr <= wrPtr + 6'd1;
                            if (wrPtr == LAST_IDX) begin
                                state       <= READY;
                                shuffleFlag <= 1'b0;
                                deckReady   <= 1'b1;
                                cardsLeft   <= FULL_CNT;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_deck_dealer.sv
// tb/tb_deck_dealer.sv - self-checking bench for deck_dealer
module tb_deck_dealer;

    logic       clk = 1'b0;
    logic       rst;
    logic       newDeck;
    logic       loadFlag;
    logic [5:0] card;
    logic       shuffleFlag;
    logic       dealReq;
    logic       dealValid;
    logic [5:0] dealCard;
    logic [3:0] rank;
    logic [1:0] suit;
    logic [5:0] cardsLeft;
    logic       deckReady;
    logic       deckEmpty;
    logic       loadErr;

    always #5 clk = ~clk;

    deck_dealer #(.DECK_SIZE(52), .CARD_W(6)) dut (
        .clk(clk), .rst(rst), .newDeck(newDeck), .loadFlag(loadFlag), .card(card),
        .shuffleFlag(shuffleFlag), .dealReq(dealReq), .dealValid(dealValid),
        .dealCard(dealCard), .rank(rank), .suit(suit), .cardsLeft(cardsLeft),
        .deckReady(deckReady), .deckEmpty(deckEmpty), .loadErr(loadErr)
    );

    typedef struct {
        int c;
        int r;
        int s;
        int left;
    } exp_t;

    typedef struct {
        int code;
        int r;
        int s;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    int   deck_q[$];
    bit   mseen[64];
    bit   model_ready;
    vec_t tbl[8];
    exp_t got;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rank_of(input int c);
        return (c % 13) + 1;
    endfunction

    function automatic int suit_of(input int c);
        return c / 13;
    endfunction

    // Compare every dealt card against the oldest expected entry
    always @(negedge clk) begin
        if (rst === 1'b1 && dealValid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_dealValid", 1, 0);
            end else begin
                got = sb.pop_front();
                chk("sb_dealCard", dealCard, got.c);
                chk("sb_rank", rank, got.r);
                chk("sb_suit", suit, got.s);
                chk("sb_cardsLeft", cardsLeft, got.left);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        deck_q.delete();
        for (int i = 0; i < 64; i++) mseen[i] = 1'b0;
        model_ready = 1'b0;
    endtask

    task automatic start_load();
        newDeck = 1'b1;
        step();
        newDeck = 1'b0;
        clear_model();
    endtask

    task automatic beat(input logic v, input int c);
        loadFlag = v;
        card     = 6'(c);
        if (v && !model_ready && c < 52 && !mseen[c]) begin
            mseen[c] = 1'b1;
            deck_q.push_back(c);
            if (deck_q.size() == 52) model_ready = 1'b1;
        end
        step();
    endtask

    task automatic deal_cycles(input int n);
        exp_t e;
        dealReq = 1'b1;
        for (int k = 0; k < n; k++) begin
            if (model_ready && deck_q.size() > 0) begin
                e.c    = deck_q.pop_front();
                e.r    = rank_of(e.c);
                e.s    = suit_of(e.c);
                e.left = deck_q.size();
                sb.push_back(e);
                if (deck_q.size() == 0) model_ready = 1'b0;
            end
            step();
        end
        dealReq = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_shuffleFlag"}, shuffleFlag, 0);
        chk({tag, "_dealValid"}, dealValid, 0);
        chk({tag, "_deckReady"}, deckReady, 0);
        chk({tag, "_deckEmpty"}, deckEmpty, 0);
        chk({tag, "_loadErr"}, loadErr, 0);
        chk({tag, "_dealCard"}, dealCard, 0);
        chk({tag, "_rank"}, rank, 0);
        chk({tag, "_suit"}, suit, 0);
        chk({tag, "_cardsLeft"}, cardsLeft, 0);
    endtask

    initial begin
        int sf_count;

        tbl[0] = '{43, 5, 3};
        tbl[1] = '{0, 1, 0};
        tbl[2] = '{12, 13, 0};
        tbl[3] = '{13, 1, 1};
        tbl[4] = '{25, 13, 1};
        tbl[5] = '{26, 1, 2};
        tbl[6] = '{38, 13, 2};
        tbl[7] = '{51, 13, 3};

        rst = 1'b0; newDeck = 1'b0; loadFlag = 1'b0; card = 6'd0; dealReq = 1'b0;
        clear_model();

        // Reset then idle
        step();
        step();
        rst = 1'b1;
        repeat (5) step();
        chk_reset_outputs("idle");
        deal_cycles(3);
        step();
        chk("idle_deal_dealValid", dealValid, 0);

        // Full load, back-to-back stream (i*5+43) mod 52
        start_load();
        chk("load_shuffleFlag_on", shuffleFlag, 1);
        sf_count = 0;
        for (int i = 0; i < 52; i++) begin
            if (shuffleFlag) sf_count++;
            beat(1'b1, (i * 5 + 43) % 52);
        end
        loadFlag = 1'b0;
        chk("load_shuffle_cycles", sf_count, 52);
        chk("load_deckReady", deckReady, 1);
        chk("load_shuffleFlag_off", shuffleFlag, 0);
        chk("load_cardsLeft", cardsLeft, 52);
        chk("load_loadErr", loadErr, 0);
        deal_cycles(1);
        chk("first_dealValid", dealValid, 1);
        chk("first_dealCard", dealCard, 43);
        chk("first_rank", rank, 5);
        chk("first_suit", suit, 3);
        deal_cycles(51);
        chk("last_dealValid", dealValid, 1);
        chk("last_deckEmpty", deckEmpty, 1);
        chk("last_cardsLeft", cardsLeft, 0);
        chk("last_deckReady", deckReady, 0);
        deal_cycles(3);
        step();
        chk("empty_hold_dealCard", dealCard, 38);
        chk("empty_hold_rank", rank, 13);
        chk("empty_hold_suit", suit, 2);
        chk("empty_deckEmpty", deckEmpty, 1);

        // Gapped stream with bad codes, ignored dealReq/newDeck during load
        start_load();
        chk("reload_deckEmpty", deckEmpty, 0);
        for (int i = 0; i < 52; i++) begin
            if (i == 10) beat(1'b1, 60);
            if (i == 11) chk("bad_range_loadErr", loadErr, 1);
            if (i == 20) beat(1'b1, (5 * 7 + 3) % 52);
            beat(1'b1, (i * 7 + 3) % 52);
            if (i == 40) chk("gap_shuffleFlag", shuffleFlag, 1);
            if (i == 51) chk("gap_deckReady_at_52", deckReady, 1);
            if (i == 30) begin
                newDeck = 1'b1;
                dealReq = 1'b1;
            end
            beat(1'b0, 0);
            newDeck = 1'b0;
            dealReq = 1'b0;
            if (i == 30) chk("load_ignored_dealValid", dealValid, 0);
        end
        chk("gap_ready", deckReady, 1);
        chk("gap_loadErr_sticky", loadErr, 1);
        chk("gap_cardsLeft", cardsLeft, 52);
        deal_cycles(52);
        step();
        chk("gap_deckEmpty", deckEmpty, 1);

        // Table-driven decode, then newDeck+dealReq precedence
        start_load();
        chk("tbl_loadErr_cleared", loadErr, 0);
        for (int k = 0; k < 8; k++) beat(1'b1, tbl[k].code);
        for (int c = 0; c < 52; c++) if (!mseen[c]) beat(1'b1, c);
        loadFlag = 1'b0;
        chk("tbl_deckReady", deckReady, 1);
        for (int k = 0; k < 8; k++) begin
            deal_cycles(1);
            chk("tbl_dealCard", dealCard, tbl[k].code);
            chk("tbl_rank", rank, tbl[k].r);
            chk("tbl_suit", suit, tbl[k].s);
        end
        deal_cycles(2);
        newDeck = 1'b1;
        dealReq = 1'b1;
        step();
        newDeck = 1'b0;
        dealReq = 1'b0;
        clear_model();
        chk("prec_dealValid", dealValid, 0);
        chk("prec_shuffleFlag", shuffleFlag, 1);
        chk("prec_deckReady", deckReady, 0);
        chk("prec_cardsLeft", cardsLeft, 0);

        // Reload, deal 10, then asynchronous reset mid-deal
        for (int i = 0; i < 52; i++) beat(1'b1, (i * 11 + 1) % 52);
        loadFlag = 1'b0;
        chk("rst_pre_deckReady", deckReady, 1);
        deal_cycles(10);
        chk("rst_pre_cardsLeft", cardsLeft, 42);
        step();
        rst = 1'b0;
        clear_model();
        #1;
        chk_reset_outputs("async_rst");
        step();
        rst = 1'b1;
        deal_cycles(3);
        step();
        chk("post_rst_dealValid", dealValid, 0);
        chk("post_rst_deckReady", deckReady, 0);
        chk("post_rst_shuffleFlag", shuffleFlag, 0);

        step();
        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
